// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB slave with eight word registers; APB_REG_SLAVE_WAIT_EN enables WAITCFG wait states
module apb_reg_slave #(
    parameter logic [31:0] ID_VALUE   = 32'hA5B0_0001,
    parameter logic [3:0]  RESET_WAIT = 4'd0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic        PSELx,
    input  logic        PENABLE,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [31:0] i_status,
    output logic [31:0] o_ctrl
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic [31:0] reg4;
    logic [31:0] rdata;
    logic [31:0] waitcfg_rd;
    logic [2:0]  idx;
    logic        dec_err;
    logic        ro_write;
    logic        wait_zero;
    logic        wr_en;

    assign idx      = PADDR[4:2];
    assign dec_err  = (PADDR[31:5] != 27'd0) || (PADDR[1:0] != 2'b00);
    assign ro_write = PWRITE && ((idx == 3'd5) || (idx == 3'd7));

    assign PREADY  = (state == ACCESS) && wait_zero;
    assign PSLVERR = PREADY && (dec_err || ro_write);
    assign PRDATA  = (PREADY && !PWRITE && !PSLVERR) ? rdata : 32'h0;
    assign o_ctrl  = reg0;

    // Commit only on the edge that ends a completed, error-free write access.
    assign wr_en = PSELx && PENABLE && PREADY && PWRITE && !PSLVERR;

`ifdef APB_REG_SLAVE_WAIT_EN
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] waitcfg;

    assign wait_zero  = (cnt == 4'd0);
    assign waitcfg_rd = {28'd0, waitcfg};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt     <= 4'd0;
            waitcfg <= RESET_WAIT;
        end else begin
            cnt <= cnt_nxt;
            if (wr_en && (idx == 3'd6)) begin
                waitcfg <= PWDATA[3:0];
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    cnt_nxt = waitcfg;
                end
            end
            ACCESS: begin
                if (PSELx && (cnt != 4'd0)) begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: cnt_nxt = 4'd0;
        endcase
    end
`else
    logic unused_reset_wait;

    assign wait_zero         = 1'b1;
    assign waitcfg_rd        = 32'h0;
    assign unused_reset_wait = ^RESET_WAIT;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped PSELx abandons the access; PREADY ends it normally.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSELx || PREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            reg0 <= 32'h0;
            reg1 <= 32'h0;
            reg2 <= 32'h0;
            reg3 <= 32'h0;
            reg4 <= 32'h0;
        end else if (wr_en) begin
            case (idx)
                3'd0:    reg0 <= PWDATA;
                3'd1:    reg1 <= PWDATA;
                3'd2:    reg2 <= PWDATA;
                3'd3:    reg3 <= PWDATA;
                3'd4:    reg4 <= PWDATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (idx)
            3'd0:    rdata = reg0;
            3'd1:    rdata = reg1;
            3'd2:    rdata = reg2;
            3'd3:    rdata = reg3;
            3'd4:    rdata = reg4;
            3'd5:    rdata = i_status;
            3'd6:    rdata = waitcfg_rd;
            3'd7:    rdata = ID_VALUE;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - scoreboard bench for apb_reg_slave
module tb_apb_reg_slave;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] i_status;
    logic [31:0] o_ctrl;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   wait_cnt = 0;

    apb_reg_slave dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .i_status (i_status),
        .o_ctrl   (o_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per completed access.
    always @(negedge i_clk) begin
        checks++;
        if (PSLVERR && !PREADY) begin
            errors++;
            $display("FAIL pslverr_without_pready: got 1 expected 0");
        end
        if (PSELx && PENABLE && !i_reset) begin
            if (PREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32({e.name, "_prdata"}, PRDATA, e.rdata);
                    check32({e.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
                    check32({e.name, "_waits"}, wait_cnt, e.waits);
                end
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge ending the access.
    task automatic apb(input string name, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_waits);
        int n;
        exp_t e;
        e.name  = name;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.waits = exp_waits;
        exp_q.push_back(e);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge i_clk);
        #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!PREADY && n < 40);
        if (!PREADY) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got PREADY=0 expected 1", name);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset  = 1'b1;
        PADDR    = 32'h0;
        PWRITE   = 1'b0;
        PWDATA   = 32'h0;
        PSELx    = 1'b0;
        PENABLE  = 1'b0;
        i_status = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        check32("rst_pready", {31'd0, PREADY}, 32'd0);
        check32("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check32("rst_prdata", PRDATA, 32'h0);
        check32("rst_ctrl", o_ctrl, 32'h0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        apb("wr_r0", 1'b1, 32'h00, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        idle();
        check32("ctrl_after_wr", o_ctrl, 32'hDEAD_BEEF);
        apb("rd_r0", 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        idle();

        apb("rd_id", 1'b0, 32'h1C, 32'h0, 32'hA5B0_0001, 1'b0, 0);
        apb("wr_id", 1'b1, 32'h1C, 32'h1, 32'h0, 1'b1, 0);
        apb("rd_id2", 1'b0, 32'h1C, 32'h0, 32'hA5B0_0001, 1'b0, 0);
        idle();

        apb("rd_0x20", 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 0);
        apb("rd_0x02", 1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 0);
        apb("wr_0x20", 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b1, 0);
        apb("wr_0x01", 1'b1, 32'h01, 32'h2222_2222, 32'h0, 1'b1, 0);
        apb("rd_r0_keep", 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        idle();
        check32("ctrl_keep", o_ctrl, 32'hDEAD_BEEF);

        i_status = 32'h1234_5678;
        apb("rd_status", 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0, 0);
        apb("wr_status", 1'b1, 32'h14, 32'h0, 32'h0, 1'b1, 0);
        idle();

        apb("b2b_wr1", 1'b1, 32'h04, 32'h1, 32'h0, 1'b0, 0);
        apb("b2b_wr2", 1'b1, 32'h08, 32'h2, 32'h0, 1'b0, 0);
        apb("b2b_rd1", 1'b0, 32'h04, 32'h0, 32'h1, 1'b0, 0);
        apb("b2b_rd2", 1'b0, 32'h08, 32'h0, 32'h2, 1'b0, 0);
        idle();

        // PENABLE without a setup phase must be ignored.
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h00;
        PWDATA  = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check32("no_setup_pready", {31'd0, PREADY}, 32'd0);
        end
        @(posedge i_clk);
        #1;
        idle();
        apb("rd_no_setup", 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        idle();

`ifdef APB_REG_SLAVE_WAIT_EN
        apb("wr_wait3", 1'b1, 32'h18, 32'h3, 32'h0, 1'b0, 0);
        idle();
        apb("rd_status_w3", 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0, 3);
        apb("rd_wcfg3", 1'b0, 32'h18, 32'h0, 32'h3, 1'b0, 3);
        apb("wr_wait2", 1'b1, 32'h18, 32'hFFFF_FFF2, 32'h0, 1'b0, 3);
        apb("rd_wcfg2", 1'b0, 32'h18, 32'h0, 32'h2, 1'b0, 2);
        idle();
`else
        apb("wr_wcfg_off", 1'b1, 32'h18, 32'h5, 32'h0, 1'b0, 0);
        apb("rd_wcfg_off", 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, 0);
        idle();
`endif

        // Reset lands inside a write's access phase, before any sampling edge.
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h00;
        PWDATA  = 32'hCAFE_F00D;
        @(posedge i_clk);
        #1;
        PENABLE = 1'b1;
        #1;
        i_reset = 1'b1;
        #1;
        check32("abort_pready", {31'd0, PREADY}, 32'd0);
        check32("abort_ctrl", o_ctrl, 32'h0);
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        idle();
        apb("rd_r0_post", 1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 0);
        apb("rd_r1_post", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 0);
        apb("rd_wcfg_post", 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, 0);
        idle();
        check32("ctrl_post", o_ctrl, 32'h0);

        repeat (3) @(posedge i_clk);
        check32("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter: ID_VALUE, 32'hA5B0_0001, constant returned by register 7 (ID).
REQ-002 Parameter: RESET_WAIT, 4'd0, reset value of WAITCFG[3:0].
REQ-003 Port: i_clk  input  1  APB clock; all state changes on rising edge.
REQ-004 Port: i_reset  input  1  asynchronous, active-high reset.
REQ-005 Port: PADDR  input  32  APB address.
REQ-006 Port: PWRITE  input  1  1 = write, 0 = read.
REQ-007 Port: PWDATA  input  32  APB write data.
REQ-008 Port: PSELx  input  1  slave select.
REQ-009 Port: PENABLE  input  1  access-phase indicator.
REQ-010 Port: PRDATA  output  32  read data.
REQ-011 Port: PREADY  output  1  transfer-complete indicator.
REQ-012 Port: PSLVERR  output  1  transfer error, valid only with PREADY.
REQ-013 Port: i_status  input  32  user status, readable at register 5.
REQ-014 Port: o_ctrl  output  32  current contents of register 0.

Function
REQ-015 The block SHALL decode 8 word registers at PADDR[4:2]: 0-4 RW, 5 STATUS RO (i_status), 6 WAITCFG RW (bits [3:0] only, [31:4] read 0), 7 ID RO (ID_VALUE).
REQ-016 The block SHALL flag a decode error when PADDR[31:5] != 0 or PADDR[1:0] != 0.
REQ-017 The FSM SHALL have states IDLE and ACCESS; IDLE->ACCESS when PSELx && !PENABLE (setup phase), loading wait counter cnt from WAITCFG[3:0].
REQ-018 In ACCESS, PREADY SHALL be 1 iff cnt == 0 (combinational); while cnt != 0 and PSELx, cnt SHALL decrement by 1 per cycle.
REQ-019 ACCESS->IDLE on the edge ending the cycle with PREADY=1; a new setup phase in the next cycle SHALL be accepted (back-to-back).
REQ-020 If PSELx falls while in ACCESS, the FSM SHALL return to IDLE with no register update.
REQ-021 PENABLE=1 observed in IDLE (no setup phase) SHALL be ignored: PREADY=0, no update.
REQ-022 Writes SHALL commit only on the edge ending a completed access (PSELx && PENABLE && PREADY && PWRITE) to a valid RW address; PWDATA and PADDR are sampled at that edge.
REQ-023 Write to register 5 or 7, or decode error, SHALL assert PSLVERR=1 with PREADY and leave all registers unchanged.
REQ-024 PRDATA SHALL equal the addressed register when PREADY && !PWRITE && !PSLVERR, and 32'h0 otherwise.
REQ-025 PSLVERR SHALL be 0 whenever PREADY is 0.
REQ-026 A write to WAITCFG SHALL affect only transfers whose setup phase follows the commit edge.
REQ-027 o_ctrl SHALL reflect register 0 from the cycle after its write commits.

Reset
REQ-028 On i_reset=1 (asynchronous): FSM=IDLE, cnt=0, registers 0-4 = 32'h0, WAITCFG = RESET_WAIT; PREADY=0, PSLVERR=0, PRDATA=0, o_ctrl=0.
REQ-029 Reset asserted mid-transfer SHALL abort it with no register update; first transfer accepted is the first setup phase after i_reset falls.

Configuration
REQ-030 Macro APB_REG_SLAVE_WAIT_EN: when defined, wait states per REQ-017/018 from WAITCFG (0-15 cycles).
REQ-031 Without APB_REG_SLAVE_WAIT_EN: cnt is not implemented, PREADY=1 in every ACCESS cycle (zero-wait), register 6 reads 32'h0, and writes to it complete with PSLVERR=0 and no effect.

Verification
REQ-032 Reset, write 32'hDEAD_BEEF to 0x00, read 0x00 -> PREADY in cycle 2 of each transfer, PRDATA=32'hDEAD_BEEF, o_ctrl=32'hDEAD_BEEF, PSLVERR=0.
REQ-033 Read 0x1C -> PRDATA=32'hA5B0_0001; write 0x1C with 32'h1 -> PSLVERR=1, subsequent read still 32'hA5B0_0001.
REQ-034 Read 0x20 and read 0x02 -> PSLVERR=1, PRDATA=0; no register changes.
REQ-035 (WAIT_EN) Write 32'h3 to 0x18, then read 0x14 with i_status=32'h1234_5678 -> PREADY low for 3 access cycles, high on the 4th, PRDATA=32'h1234_5678.
REQ-036 Assert i_reset during a write's access phase with WAITCFG=2 -> PREADY=0 immediately, register unchanged, o_ctrl=0.
REQ-037 Two back-to-back writes (0x04 = 32'h1, then 0x08 = 32'h2) with PSELx held high -> both commit, reads return 32'h1 and 32'h2.
